maxpool_window_buffer: RTL and testbench

Streaming window former that sits directly upstream of the max-pool stage. It accepts one feature-map pixel per valid cycle in raster order and buffers STRIDE_SIZE−1 rows plus a short row shift register. Each time a complete non-overlapping STRIDE_SIZE×STRIDE_SIZE window is available, it presents the whole window as one packed word with a one-cycle valid strobe.

---
 rtl/maxpool_window_buffer_pkg.sv | 36 +++
 rtl/maxpool_window_buffer_line_buf.sv | 50 +++++
 rtl/maxpool_window_buffer.sv | 127 ++++++++++++
 tb/tb_maxpool_window_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_window_buffer_pkg.sv
// Shared geometry helpers for the max-pool window former and the max-pool stage.
// Both sides use the same window packing: element (r, c) sits at index r*S + c.
package maxpool_window_buffer_pkg;

  // Default geometry of the pooling path.
  localparam int DEF_STRIDE_SIZE = 2;
  localparam int DEF_ROW_SIZE    = 4;
  localparam int DEF_COLUMN_SIZE = 4;

  // Index of window element at relative row r, column c.
  function automatic int win_idx(input int r, input int c, input int s);
    return r * s + c;
  endfunction

  // Counter width for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Number of elements in one S x S window.
  function automatic int num_inp(input int s);
    return s * s;
  endfunction

  // Extent covered by whole windows; anything at or beyond it is never emitted.
  function automatic int emit_span(input int n, input int s);
    return (n / s) * s;
  endfunction

  localparam int NUM_INP   = num_inp(DEF_STRIDE_SIZE);
  localparam int EMIT_COLS = emit_span(DEF_ROW_SIZE, DEF_STRIDE_SIZE);
  localparam int EMIT_ROWS = emit_span(DEF_COLUMN_SIZE, DEF_STRIDE_SIZE);

endpackage

// File: rtl/maxpool_window_buffer_line_buf.sv
// Line buffer holding the first S-1 rows of each window band.
// Written one pixel at a time, read combinationally as an (S-1) x S block.
module window_line_buffer
  import maxpool_window_buffer_pkg::*;
#(
  parameter int STRIDE_SIZE = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ROW_SIZE    = 4,
  parameter int CW          = cnt_width(ROW_SIZE),
  parameter int LB_RW       = cnt_width(STRIDE_SIZE - 1)
) (
  input  logic                                                 clock,
  input  logic                                                 i_wr_en,
  input  logic [LB_RW-1:0]                                     i_wr_row,
  input  logic [CW-1:0]                                        i_wr_col,
  input  logic [DATA_WIDTH-1:0]                                i_wr_data,
  input  logic [CW-1:0]                                        i_rd_col,
  output logic [(STRIDE_SIZE-1)*STRIDE_SIZE*DATA_WIDTH-1:0]    o_rd_data
);

  localparam int ROWS = STRIDE_SIZE - 1;

  logic [DATA_WIDTH-1:0] r_mem [ROWS][ROW_SIZE];

  // Store the accepted pixel in its band row / column slot.
  // NOTE: storage arrays carry no reset; every slot is rewritten before it is read.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_row][i_wr_col] <= i_wr_data;
    end
  end

  // Gather the S columns starting at i_rd_col for every buffered row.
  // NOTE: combinational outputs get a default first so no latch is inferred.
  always_comb begin
    logic [CW:0] w_col_ext;
    o_rd_data = '0;
    w_col_ext = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < STRIDE_SIZE; c++) begin
        w_col_ext = {1'b0, i_rd_col} + (CW+1)'(c);
        if (w_col_ext < (CW+1)'(ROW_SIZE)) begin
          o_rd_data[win_idx(r, c, STRIDE_SIZE)*DATA_WIDTH +: DATA_WIDTH] =
            r_mem[r][w_col_ext[CW-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/maxpool_window_buffer.sv
// Streaming S x S window former feeding the max-pool stage.
// Tracks raster position, buffers S-1 rows plus a short row shift register,
// and emits each complete non-overlapping window one cycle after its last pixel.
module maxpool_window_buffer
  import maxpool_window_buffer_pkg::*;
#(
  parameter int STRIDE_SIZE = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ROW_SIZE    = 4,
  parameter int COLUMN_SIZE = 4
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [DATA_WIDTH-1:0]                             pixel_in,
  input  logic                                              pixel_in_valid,
  output logic [STRIDE_SIZE*STRIDE_SIZE*DATA_WIDTH-1:0]     window_out,
  output logic                                              window_valid,
  output logic                                              frame_done
);

  localparam int S           = STRIDE_SIZE;
  localparam int WIN_ELEMS   = num_inp(S);
  localparam int COL_LIMIT   = emit_span(ROW_SIZE, S);
  localparam int ROW_LIMIT   = emit_span(COLUMN_SIZE, S);
  localparam int CW          = cnt_width(ROW_SIZE);
  localparam int RW          = cnt_width(COLUMN_SIZE);
  localparam int LB_RW       = cnt_width(S - 1);
  localparam int WW          = WIN_ELEMS * DATA_WIDTH;
  localparam int LBW         = (S - 1) * S * DATA_WIDTH;

  logic [CW-1:0]         r_col_cnt;
  logic [RW-1:0]         r_row_cnt;
  logic [DATA_WIDTH-1:0] r_shift [S-1];
  logic [WW-1:0]         r_window;
  logic                  r_window_valid;
  logic                  r_frame_done;

  int                    w_col_mod;
  int                    w_row_mod;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_emit;
  logic                  w_lb_wr;
  logic [CW-1:0]         w_rd_col;
  logic [LBW-1:0]        w_lb_rd;
  logic [WW-1:0]         w_window;

  assign w_col_mod  = int'(r_col_cnt) % S;
  assign w_row_mod  = int'(r_row_cnt) % S;
  assign w_col_last = (r_col_cnt == CW'(ROW_SIZE - 1));
  assign w_row_last = (r_row_cnt == RW'(COLUMN_SIZE - 1));

  // A window completes on the bottom-right pixel of a full S x S tile.
  assign w_emit = pixel_in_valid && (w_col_mod == S - 1) && (w_row_mod == S - 1) &&
                  (int'(r_col_cnt) < COL_LIMIT) && (int'(r_row_cnt) < ROW_LIMIT);

  // Only the upper S-1 rows of a band are buffered; the bottom row streams through.
  assign w_lb_wr  = pixel_in_valid && !reset && (w_row_mod < S - 1);
  assign w_rd_col = r_col_cnt - CW'(S - 1);

  window_line_buffer #(
    .STRIDE_SIZE (S),
    .DATA_WIDTH  (DATA_WIDTH),
    .ROW_SIZE    (ROW_SIZE),
    .CW          (CW),
    .LB_RW       (LB_RW)
  ) u_line_buf (
    .clock     (clock),
    .i_wr_en   (w_lb_wr),
    .i_wr_row  (LB_RW'(w_row_mod)),
    .i_wr_col  (r_col_cnt),
    .i_wr_data (pixel_in),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_lb_rd)
  );

  // Assemble the window: buffered rows on top, shift register plus live pixel at the bottom.
  always_comb begin
    w_window = '0;
    w_window[LBW-1:0] = w_lb_rd;
    for (int c = 0; c < S - 1; c++) begin
      w_window[win_idx(S - 1, c, S)*DATA_WIDTH +: DATA_WIDTH] = r_shift[S - 2 - c];
    end
    w_window[win_idx(S - 1, S - 1, S)*DATA_WIDTH +: DATA_WIDTH] = pixel_in;
  end

  // Keep the S-1 most recent pixels of the current row; entry 0 is the newest.
  always_ff @(posedge clock) begin
    if (pixel_in_valid && !reset) begin
      r_shift[0] <= pixel_in;
      for (int i = 1; i < S - 1; i++) begin
        r_shift[i] <= r_shift[i - 1];
      end
    end
  end

  // Raster counters and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col_cnt      <= '0;
      r_row_cnt      <= '0;
      r_window       <= '0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_window_valid <= w_emit;
      r_frame_done   <= pixel_in_valid && w_col_last && w_row_last;
      if (w_emit) begin
        r_window <= w_window;
      end
      if (pixel_in_valid) begin
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_last ? '0 : r_row_cnt + RW'(1);
        end else begin
          r_col_cnt <= r_col_cnt + CW'(1);
        end
      end
    end
  end

  assign window_out   = r_window;
  assign window_valid = r_window_valid;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_maxpool_window_buffer.sv
// Bench for maxpool_window_buffer: three geometries (S=2 4x4, S=2 5x5, S=3 6x6)
// compared cycle by cycle against a frame-array reference model.
module tb_maxpool_window_buffer;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a = 1'b1, vld_a = 1'b0, wv_a, fd_a;
  logic [DW-1:0] px_a  = '0;
  logic [63:0]   win_a;
  logic          rst_b = 1'b1, vld_b = 1'b0, wv_b, fd_b;
  logic [DW-1:0] px_b  = '0;
  logic [63:0]   win_b;
  logic          rst_c = 1'b1, vld_c = 1'b0, wv_c, fd_c;
  logic [DW-1:0] px_c  = '0;
  logic [143:0]  win_c;

  maxpool_window_buffer #(.STRIDE_SIZE(2), .DATA_WIDTH(DW), .ROW_SIZE(4), .COLUMN_SIZE(4)) dut_a (
    .clock(clk), .reset(rst_a), .pixel_in(px_a), .pixel_in_valid(vld_a),
    .window_out(win_a), .window_valid(wv_a), .frame_done(fd_a));

  maxpool_window_buffer #(.STRIDE_SIZE(2), .DATA_WIDTH(DW), .ROW_SIZE(5), .COLUMN_SIZE(5)) dut_b (
    .clock(clk), .reset(rst_b), .pixel_in(px_b), .pixel_in_valid(vld_b),
    .window_out(win_b), .window_valid(wv_b), .frame_done(fd_b));

  maxpool_window_buffer #(.STRIDE_SIZE(3), .DATA_WIDTH(DW), .ROW_SIZE(6), .COLUMN_SIZE(6)) dut_c (
    .clock(clk), .reset(rst_c), .pixel_in(px_c), .pixel_in_valid(vld_c),
    .window_out(win_c), .window_valid(wv_c), .frame_done(fd_c));

  // Geometry of each instance: stride, pixels per row, rows per frame.
  int s_t  [3] = '{2, 2, 3};
  int rs_t [3] = '{4, 5, 6};
  int cs_t [3] = '{4, 5, 6};

  // Reference model state: the frame seen so far, pixels accepted in this frame,
  // the last window that should be on window_out, and observed pulse counts.
  int           img      [3][6][6];
  int           kcnt     [3];
  logic [143:0] last_win [3];
  int           obs_win  [3];
  int           obs_done [3];

  int total = 0;
  int bad   = 0;

  // One clock of stimulus on instance id, then compare its outputs with the model.
  task automatic send(input int id, input logic [DW-1:0] p, input logic v, input logic r);
    logic [143:0] got_w, w;
    logic         got_v, got_d, exp_v, exp_d;
    int           s, rs, cs, rr, cc;
    @(negedge clk);
    case (id)
      0:       begin px_a = p; vld_a = v; rst_a = r; end
      1:       begin px_b = p; vld_b = v; rst_b = r; end
      default: begin px_c = p; vld_c = v; rst_c = r; end
    endcase
    @(posedge clk);
    #1;
    case (id)
      0:       begin got_w = {80'b0, win_a}; got_v = wv_a; got_d = fd_a; end
      1:       begin got_w = {80'b0, win_b}; got_v = wv_b; got_d = fd_b; end
      default: begin got_w = win_c;          got_v = wv_c; got_d = fd_c; end
    endcase
    s = s_t[id]; rs = rs_t[id]; cs = cs_t[id];
    exp_v = 1'b0;
    exp_d = 1'b0;
    if (r) begin
      kcnt[id]     = 0;
      last_win[id] = '0;
    end else if (v) begin
      rr = kcnt[id] / rs;
      cc = kcnt[id] % rs;
      img[id][rr][cc] = int'(p);
      if ((rr % s == s - 1) && (cc % s == s - 1) && (cc < (rs / s) * s) && (rr < (cs / s) * s)) begin
        exp_v = 1'b1;
        w = '0;
        for (int i = 0; i < s; i++)
          for (int j = 0; j < s; j++)
            w[(i * s + j) * DW +: DW] = DW'(img[id][rr - s + 1 + i][cc - s + 1 + j]);
        last_win[id] = w;
      end
      exp_d    = (kcnt[id] == rs * cs - 1);
      kcnt[id] = (kcnt[id] + 1) % (rs * cs);
    end
    if (got_v) obs_win[id]++;
    if (got_d) obs_done[id]++;
    total += 3;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL window_valid dut=%0d t=%0t got=%b want=%b", id, $time, got_v, exp_v);
    end
    if (got_d !== exp_d) begin
      bad++;
      $display("FAIL frame_done dut=%0d t=%0t got=%b want=%b", id, $time, got_d, exp_d);
    end
    if (got_w !== last_win[id]) begin
      bad++;
      $display("FAIL window_out dut=%0d t=%0t got=%h want=%h", id, $time, got_w, last_win[id]);
    end
    case (id)
      0:       begin vld_a = 1'b0; rst_a = 1'b0; end
      1:       begin vld_b = 1'b0; rst_b = 1'b0; end
      default: begin vld_c = 1'b0; rst_c = 1'b0; end
    endcase
  endtask

  task automatic test_reset();
    for (int id = 0; id < 3; id++) begin
      send(id, 16'hffff, 1'b1, 1'b1);
      send(id, 16'h0, 1'b0, 1'b1);
      send(id, 16'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_basic();
    logic [63:0] want;
    obs_win[0] = 0; obs_done[0] = 0;
    for (int p = 1; p <= 16; p++) begin
      send(0, DW'(p), 1'b1, 1'b0);
      if (p == 6) begin
        want = {16'd6, 16'd5, 16'd2, 16'd1};
        total++;
        if (win_a !== want) begin
          bad++;
          $display("FAIL basic_first_window got=%h want=%h", win_a, want);
        end
      end
    end
    total++;
    if (obs_win[0] != 4 || obs_done[0] != 1) begin
      bad++;
      $display("FAIL basic_counts windows=%0d done=%0d want 4/1", obs_win[0], obs_done[0]);
    end
  endtask

  task automatic test_gaps();
    obs_win[0] = 0;
    for (int p = 1; p <= 16; p++) begin
      send(0, DW'(p), 1'b1, 1'b0);
      if (p == 2 || p == 5 || p == 11)
        for (int g = 0; g < 3; g++) send(0, 16'hdead, 1'b0, 1'b0);
    end
    total++;
    if (obs_win[0] != 4) begin
      bad++;
      $display("FAIL gaps_count windows=%0d want=4", obs_win[0]);
    end
  endtask

  task automatic test_trailing();
    obs_win[1] = 0; obs_done[1] = 0;
    for (int p = 1; p <= 25; p++) send(1, DW'(p), 1'b1, 1'b0);
    total++;
    if (obs_win[1] != 4 || obs_done[1] != 1) begin
      bad++;
      $display("FAIL trailing_counts windows=%0d done=%0d want 4/1", obs_win[1], obs_done[1]);
    end
  endtask

  task automatic test_reset_mid();
    obs_win[0] = 0;
    for (int p = 1; p <= 7; p++) send(0, DW'(p), 1'b1, 1'b0);
    send(0, 16'd99, 1'b1, 1'b1);
    send(0, 16'd98, 1'b0, 1'b1);
    for (int p = 101; p <= 116; p++) send(0, DW'(p), 1'b1, 1'b0);
    total++;
    if (obs_win[0] != 5) begin
      bad++;
      $display("FAIL reset_mid_count windows=%0d want=5", obs_win[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] want;
    obs_win[0] = 0;
    for (int p = 1; p <= 32; p++) begin
      send(0, DW'(p), 1'b1, 1'b0);
      if (p == 22) begin
        want = {16'd22, 16'd21, 16'd18, 16'd17};
        total++;
        if (win_a !== want) begin
          bad++;
          $display("FAIL b2b_second_frame got=%h want=%h", win_a, want);
        end
      end
    end
    total++;
    if (obs_win[0] != 8) begin
      bad++;
      $display("FAIL b2b_count windows=%0d want=8", obs_win[0]);
    end
  endtask

  task automatic test_stride3();
    logic [143:0] want;
    obs_win[2] = 0;
    for (int p = 1; p <= 36; p++) begin
      send(2, DW'(p), 1'b1, 1'b0);
      if (p == 15) begin
        want = {16'd15, 16'd14, 16'd13, 16'd9, 16'd8, 16'd7, 16'd3, 16'd2, 16'd1};
        total++;
        if (win_c !== want) begin
          bad++;
          $display("FAIL s3_first_window got=%h want=%h", win_c, want);
        end
      end
    end
    total++;
    if (obs_win[2] != 4) begin
      bad++;
      $display("FAIL s3_count windows=%0d want=4", obs_win[2]);
    end
  endtask

  task automatic test_random();
    for (int id = 0; id < 3; id++) begin
      for (int n = 0; n < 3 * rs_t[id] * cs_t[id] + 20; n++) begin
        send(id, DW'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 79) == 0));
      end
    end
  endtask

  initial begin
    for (int id = 0; id < 3; id++) begin
      kcnt[id] = 0; last_win[id] = '0; obs_win[id] = 0; obs_done[id] = 0;
    end
    test_reset();
    test_basic();
    test_gaps();
    test_trailing();
    test_reset_mid();
    test_back_to_back();
    test_stride3();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
